// File: rtl/tlul_pkg.sv
// -----------------------------------------------------------------------------
// tlul_pkg
// Minimal TileLink Uncached Lightweight (TL-UL) channel types used by the
// register port of vicuna_core_ctrl. Only the fields a 32-bit register device
// needs are carried.
//   tl_h2d_t : host -> device (A channel request plus d_ready)
//   tl_d2h_t : device -> host (D channel response plus a_ready)
// -----------------------------------------------------------------------------
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage : tlul_pkg

// File: rtl/vicuna_core_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vicuna_core_ctrl_pkg
// Shared definitions for the Vicuna worker-core controller: the per-core state
// encoding (also the value reported in STATUS) and the register map.
// -----------------------------------------------------------------------------
package vicuna_core_ctrl_pkg;

  // Encoding is visible to software through STATUS, so values are fixed.
  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } core_state_e;

  // Byte offsets within the device window, a_address[7:0].
  localparam logic [7:0] CtrlOffset       = 8'h00;
  localparam logic [7:0] StatusOffset     = 8'h04;
  localparam logic [7:0] IrqStateOffset   = 8'h08;
  localparam logic [7:0] CyclesBaseOffset = 8'h10;

  // CTRL: start bits at [NumCores-1:0], abort bits start here.
  localparam int unsigned AbortBitOffset = 8;

  // STATUS bit that reports any latched-but-not-yet-served start.
  localparam int unsigned StatusPendingBit = 31;

endpackage : vicuna_core_ctrl_pkg

// File: rtl/vicuna_core_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// vicuna_core_ctrl_fsm
// Control for one Vicuna core: HALT/RUN/DONE state, the reset-hold counter that
// guarantees a minimum reset pulse before the core may run again, a latched
// pending start, and a saturating run-cycle counter.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   i_start        : start request (one-cycle strobe from a CTRL write)
//   i_abort        : abort request (one-cycle strobe, dominates start)
//   i_core_done    : completion from the core, only looked at in RUN
//   o_state        : current state
//   o_pending      : a start is waiting for the hold time to expire
//   o_core_rst_n   : active-low reset to the core (released only in RUN)
//   o_done_set     : RUN -> DONE this cycle, sets the core's IRQ bit
//   o_cycles       : run-cycle count
// -----------------------------------------------------------------------------
module vicuna_core_ctrl_fsm
  import vicuna_core_ctrl_pkg::*;
#(
  parameter int unsigned ResetHoldCycles = 16,
  parameter int unsigned CntW            = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_core_done,
  output core_state_e     o_state,
  output logic            o_pending,
  output logic            o_core_rst_n,
  output logic            o_done_set,
  output logic [CntW-1:0] o_cycles
);

  localparam int unsigned     HoldW   = $clog2(ResetHoldCycles);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(ResetHoldCycles - 1);

  core_state_e      r_state;
  logic [HoldW-1:0] r_hold_cnt;
  logic             r_pending;
  logic [CntW-1:0]  r_cycles;

  logic w_hold_done;
  logic w_go;

  // Hold counter saturates at HoldMax, so equality means "hold satisfied".
  // The core reset is low for the cycle of each count 0..HoldMax, i.e. for
  // ResetHoldCycles cycles, before RUN can be entered.
  assign w_hold_done = (r_hold_cnt == HoldMax);
  assign w_go        = (r_state != RUN) && !i_abort && (i_start || r_pending) && w_hold_done;
  assign o_done_set  = (r_state == RUN) && i_core_done && !i_abort;

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= HALT;
      r_hold_cnt <= '0;
      r_pending  <= 1'b0;
      r_cycles   <= '0;
    end else begin
      unique case (r_state)
        HALT, DONE: begin
          if (r_hold_cnt != HoldMax) r_hold_cnt <= r_hold_cnt + HoldW'(1);
          if (i_abort) begin
            // Abort also drops any start still waiting for the hold.
            r_state   <= HALT;
            r_pending <= 1'b0;
          end else if (w_go) begin
            r_state   <= RUN;
            r_pending <= 1'b0;
            r_cycles  <= '0;
          end else if (i_start) begin
            r_pending <= 1'b1;
          end
        end
        RUN: begin
          if (r_cycles != '1) r_cycles <= r_cycles + CntW'(1);
          // Leaving RUN re-asserts the core reset, so the hold restarts.
          if (i_abort) begin
            r_state    <= HALT;
            r_hold_cnt <= '0;
          end else if (i_core_done) begin
            r_state    <= DONE;
            r_hold_cnt <= '0;
          end
        end
        default: begin
          r_state    <= HALT;
          r_hold_cnt <= '0;
          r_pending  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_pending    = r_pending;
  assign o_core_rst_n = (r_state == RUN);
  assign o_cycles     = r_cycles;

endmodule : vicuna_core_ctrl_fsm

// File: rtl/vicuna_core_ctrl.sv
// -----------------------------------------------------------------------------
// vicuna_core_ctrl
// TL-UL register device that starts, aborts and monitors the Vicuna worker
// cores. One control FSM per core; completion is latched into a W1C IRQ_STATE
// register whose OR drives irq_done_o.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tl_i / tl_o   : TL-UL register port (single outstanding transaction)
//   core_rst_no   : per-core active-low reset to the Vicuna cores
//   core_done_i   : per-core completion (level or pulse), used only in RUN
//   irq_done_o    : OR of IRQ_STATE
// Registers (a_address[7:0]):
//   0x00 CTRL      WO  [n] start, [8+n] abort; reads 0
//   0x04 STATUS    RO  [2n+1:2n] state, [31] any start pending
//   0x08 IRQ_STATE W1C [n] core n completed
//   0x10+4n CYCLES_n RO run-cycle count, zero-extended
// -----------------------------------------------------------------------------
module vicuna_core_ctrl
  import vicuna_core_ctrl_pkg::*;
  import tlul_pkg::*;
#(
  parameter int unsigned NumCores        = 2,
  parameter int unsigned ResetHoldCycles = 16,
  parameter int unsigned CntW            = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  tl_h2d_t             tl_i,
  output tl_d2h_t             tl_o,
  output logic [NumCores-1:0] core_rst_no,
  input  logic [NumCores-1:0] core_done_i,
  output logic                irq_done_o
);

  // Per-core FSM outputs.
  core_state_e          w_state  [NumCores];
  logic [CntW-1:0]      w_cycles [NumCores];
  logic [NumCores-1:0]  w_pending;
  logic [NumCores-1:0]  w_done_set;

  // Request decode.
  logic [7:0]           w_addr;
  logic                 w_accept;
  logic                 w_is_get;
  logic                 w_is_put;
  logic                 w_hit_ctrl;
  logic                 w_hit_status;
  logic                 w_hit_irq;
  logic                 w_hit_cycles;
  logic                 w_err;
  logic [31:0]          w_status;
  logic [31:0]          w_cycles_rdata;
  logic [31:0]          w_rdata;
  logic                 w_ctrl_we;
  logic                 w_irq_we;
  logic [NumCores-1:0]  w_start;
  logic [NumCores-1:0]  w_abort;
  logic [NumCores-1:0]  w_irq_clr;

  // State.
  logic [NumCores-1:0]  r_irq;
  logic                 r_d_valid;
  tl_d_op_e             r_d_opcode;
  logic [1:0]           r_d_size;
  logic [7:0]           r_d_source;
  logic [31:0]          r_d_data;
  logic                 r_d_error;

  // Only part of the request struct carries meaning for this device.
  logic w_unused_tl;
  assign w_unused_tl = ^tl_i;

  // One transaction in flight: the response register doubles as the busy flag.
  assign w_accept = tl_i.a_valid && !r_d_valid;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_addr         = tl_i.a_address[7:0];
    w_is_get       = (tl_i.a_opcode == Get);
    w_is_put       = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    w_hit_ctrl     = (w_addr == CtrlOffset);
    w_hit_status   = (w_addr == StatusOffset);
    w_hit_irq      = (w_addr == IrqStateOffset);
    w_hit_cycles   = 1'b0;
    w_cycles_rdata = '0;
    for (int n = 0; n < int'(NumCores); n++) begin
      if (w_addr == (CyclesBaseOffset + 8'(4 * n))) begin
        w_hit_cycles   = 1'b1;
        w_cycles_rdata = 32'(w_cycles[n]);
      end
    end

    w_status = '0;
    for (int n = 0; n < int'(NumCores); n++) begin
      w_status[2*n +: 2] = w_state[n];
    end
    w_status[StatusPendingBit] = |w_pending;

    // Any error suppresses every register side effect and returns zero data.
    w_err = !(w_is_get || w_is_put)
         || (tl_i.a_size != 2'd2)
         || !(w_hit_ctrl || w_hit_status || w_hit_irq || w_hit_cycles)
         || (w_is_put && (w_hit_status || w_hit_cycles))
         || (w_is_put && (tl_i.a_mask != 4'hF));

    w_rdata = '0;
    if (w_is_get && !w_err) begin
      if (w_hit_status)      w_rdata = w_status;
      else if (w_hit_irq)    w_rdata = 32'(r_irq);
      else if (w_hit_cycles) w_rdata = w_cycles_rdata;
    end

    w_ctrl_we = w_accept && w_is_put && w_hit_ctrl && !w_err;
    w_irq_we  = w_accept && w_is_put && w_hit_irq  && !w_err;
    w_start   = w_ctrl_we ? tl_i.a_data[NumCores-1:0] : '0;
    w_abort   = w_ctrl_we ? tl_i.a_data[AbortBitOffset +: NumCores] : '0;
    w_irq_clr = w_irq_we  ? tl_i.a_data[NumCores-1:0] : '0;
  end

  for (genvar n = 0; n < NumCores; n++) begin : g_core
    vicuna_core_ctrl_fsm #(
      .ResetHoldCycles (ResetHoldCycles),
      .CntW            (CntW)
    ) u_fsm (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .i_start      (w_start[n]),
      .i_abort      (w_abort[n]),
      .i_core_done  (core_done_i[n]),
      .o_state      (w_state[n]),
      .o_pending    (w_pending[n]),
      .o_core_rst_n (core_rst_no[n]),
      .o_done_set   (w_done_set[n]),
      .o_cycles     (w_cycles[n])
    );
  end

  // A completion landing in the same cycle as its W1C clear survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq <= '0;
    end else begin
      r_irq <= (r_irq & ~w_irq_clr) | w_done_set;
    end
  end

  assign irq_done_o = |r_irq;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_d_valid  <= 1'b0;
      r_d_opcode <= AccessAck;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else if (w_accept) begin
      r_d_valid  <= 1'b1;
      r_d_opcode <= w_is_get ? AccessAckData : AccessAck;
      r_d_size   <= tl_i.a_size;
      r_d_source <= tl_i.a_source;
      r_d_data   <= w_rdata;
      r_d_error  <= w_err;
    end else if (tl_i.d_ready) begin
      r_d_valid  <= 1'b0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = r_d_valid;
    tl_o.d_opcode = r_d_opcode;
    tl_o.d_size   = r_d_size;
    tl_o.d_source = r_d_source;
    tl_o.d_data   = r_d_data;
    tl_o.d_error  = r_d_error;
    tl_o.a_ready  = !r_d_valid;
  end

endmodule : vicuna_core_ctrl
